// File: rtl/systolic_mm_engine.sv
// Output-stationary MxN systolic matrix-multiply engine. Operand skewing and zero-flush
// are internal; C rows drain over valid/ready and stay resident for tile accumulation.
module systolic_mm_engine #(
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K),
  parameter bit SIGNED     = 1'b0,
  localparam int RW        = (M > 1) ? $clog2(M) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    acc_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:M*DATA_WIDTH-1] in_a,
  input  logic [0:N*DATA_WIDTH-1] in_b,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:N*ACC_WIDTH-1]  out_c,
  output logic [RW-1:0]           out_row,
  output logic                    out_last
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = $clog2(M + N);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUTPUT} state_t;

  state_t          state, state_n;
  logic [KW-1:0]   k_cnt;
  logic [CW-1:0]   drain_cnt;
  logic            accept, enable, clear;
  logic [DW-1:0]   a_src [M];
  logic [DW-1:0]   b_src [N];
  logic [DW-1:0]   a_tap [M][M];
  logic [DW-1:0]   b_tap [N][N];
  logic [DW-1:0]   a_sk  [M][M];
  logic [DW-1:0]   b_sk  [N][N];
  logic [DW-1:0]   a_w   [M][N];
  logic [DW-1:0]   b_n   [M][N];
  logic [DW-1:0]   a_q   [M][N];
  logic [DW-1:0]   b_q   [M][N];
  logic [AW-1:0]   prod  [M][N];
  logic [AW-1:0]   acc   [M][N];
  logic [RW-1:0]   row_sel;
  logic [0:N*AW-1] row_c;

  // One extra bit lets the same signed multiplier serve both operand modes.
  function automatic logic [AW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW:0]     ae, be;
    logic signed [2*DW+1:0] p;
    ae = {SIGNED & a[DW-1], a};
    be = {SIGNED & b[DW-1], b};
    p  = ae * be;
    return AW'(p);
  endfunction

  assign in_ready = (state == IDLE) || (state == LOAD);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign enable   = accept || (state == DRAIN);
  assign clear    = accept && (state == IDLE) && !acc_mode;
  assign out_last = out_valid && (out_row == RW'(M-1));

  // NOTE: next-state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = (K == 1) ? DRAIN : LOAD;
      LOAD:    if (in_valid && k_cnt == KW'(K-1)) state_n = DRAIN;
      DRAIN:   if (drain_cnt == CW'(M+N-2)) state_n = OUTPUT;
      OUTPUT:  if (out_valid && out_ready && out_row == RW'(M-1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k_cnt     <= '0;
      drain_cnt <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_c     <= '0;
    end else begin
      state <= state_n;
      if (accept) k_cnt <= (k_cnt == KW'(K-1)) ? '0 : k_cnt + KW'(1);
      if (state == DRAIN) drain_cnt <= (drain_cnt == CW'(M+N-2)) ? '0 : drain_cnt + CW'(1);
      // Registered row stage: first OUTPUT cycle loads row 0, so C is read only after the final drain step.
      if (state == OUTPUT) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_row   <= '0;
          out_c     <= row_c;
        end else if (out_ready) begin
          if (out_row == RW'(M-1)) begin
            out_valid <= 1'b0;
            out_row   <= '0;
          end else begin
            out_row <= out_row + RW'(1);
            out_c   <= row_c;
          end
        end
      end
    end
  end

  // Tap d of each skew chain is the source delayed d enabled steps; zeros enter outside accepted beats.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      a_src[i]    = accept ? in_a[i*DW +: DW] : '0;
      a_tap[i][0] = a_src[i];
      for (int d = 1; d < M; d++) a_tap[i][d] = a_sk[i][d-1];
    end
    for (int j = 0; j < N; j++) begin
      b_src[j]    = accept ? in_b[j*DW +: DW] : '0;
      b_tap[j][0] = b_src[j];
      for (int d = 1; d < N; d++) b_tap[j][d] = b_sk[j][d-1];
    end
    for (int i = 0; i < M; i++) begin
      a_w[i][0] = a_tap[i][i];
      for (int j = 1; j < N; j++) a_w[i][j] = a_q[i][j-1];
    end
    for (int j = 0; j < N; j++) begin
      b_n[0][j] = b_tap[j][j];
      for (int i = 1; i < M; i++) b_n[i][j] = b_q[i-1][j];
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) prod[i][j] = mul(a_w[i][j], b_n[i][j]);
  end

  // NOTE: the PE array is flops, not RAM; it must clear on reset so a later acc_mode=1 op starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < M; i++) begin
        for (int d = 0; d < M; d++) a_sk[i][d] <= '0;
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          acc[i][j] <= '0;
        end
      end
      for (int j = 0; j < N; j++)
        for (int d = 0; d < N; d++) b_sk[j][d] <= '0;
    end else if (enable) begin
      for (int i = 0; i < M; i++) begin
        a_sk[i][0] <= a_src[i];
        for (int d = 1; d < M; d++) a_sk[i][d] <= a_sk[i][d-1];
      end
      for (int j = 0; j < N; j++) begin
        b_sk[j][0] <= b_src[j];
        for (int d = 1; d < N; d++) b_sk[j][d] <= b_sk[j][d-1];
      end
      // Only PE(0,0) sees a nonzero product on beat 0, so clearing every accumulator then is exact.
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= a_w[i][j];
          b_q[i][j] <= b_n[i][j];
          acc[i][j] <= (clear ? '0 : acc[i][j]) + prod[i][j];
        end
    end
  end

  always_comb begin
    row_sel = (out_valid && out_row != RW'(M-1)) ? out_row + RW'(1) : '0;
    for (int j = 0; j < N; j++) row_c[j*AW +: AW] = acc[row_sel][j];
  end

endmodule
